// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: state codes, PC ops,
// D-bus select one-hots and instruction class/sub-op fields.
package cpu_ctrl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_RST   = 3'd0;
   localparam state_t ST_FETCH = 3'd1;
   localparam state_t ST_EXEC  = 3'd2;
   localparam state_t ST_MEM   = 3'd3;
   localparam state_t ST_HALT  = 3'd4;
   localparam state_t ST_FAULT = 3'd5;

   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;
   localparam logic [1:0] PS_REL  = 2'b10;
   localparam logic [1:0] PS_REG  = 2'b11;

   localparam logic [1:0] SS_HOLD = 2'b00;
   localparam logic [1:0] SS_UPD  = 2'b01;

   localparam logic [4:0] MUXD_MEM  = 5'b00001;
   localparam logic [4:0] MUXD_K    = 5'b00010;
   localparam logic [4:0] MUXD_FU   = 5'b00100;
   localparam logic [4:0] MUXD_PC1  = 5'b01000;
   localparam logic [4:0] MUXD_ZERO = 5'b10000;

   localparam logic [1:0] CLS_ALU = 2'b00;
   localparam logic [1:0] CLS_IMM = 2'b01;
   localparam logic [1:0] CLS_MEM = 2'b10;
   localparam logic [1:0] CLS_CTL = 2'b11;

   localparam logic [1:0] CTL_BZ   = 2'b00;
   localparam logic [1:0] CTL_BN   = 2'b01;
   localparam logic [1:0] CTL_JMP  = 2'b10;
   localparam logic [1:0] CTL_HALT = 2'b11;

   // Wide enough for the largest allowed MEM_TIMEOUT (255).
   localparam int WAIT_CNT_W = 8;

   // Increment-style function codes need a carry-in of one.
   function automatic logic fs_uses_cin(input logic [4:0] fs);
      return (fs == 5'b00001) || (fs == 5'b00101);
   endfunction

endpackage

// File: rtl/cpu_ctrl_wait_timer.sv
// Counts MEM wait cycles; flags the cycle on which a further miss would
// exhaust the MEM_TIMEOUT budget.
module cpu_ctrl_wait_timer
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_timeout
);

   localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MEM_TIMEOUT - 1);

   logic [WAIT_CNT_W-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_count <= '0;
      else if (i_clr)
         r_count <= '0;
      else if (i_inc)
         r_count <= r_count + 1'b1;
   end

   assign o_timeout = (r_count == LIMIT);

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit: FETCH/EXEC/MEM/HALT/FAULT sequencing with the
// datapath control word decoded combinationally from state, IR and status.
module cpu_control_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int IR_W        = 16,
   parameter int RA_W        = 3,
   parameter int K_W         = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [IR_W-1:0] IR,
   input  logic [3:0]      status,
   input  logic            mem_ready,
   input  logic            run,
   output logic [1:0]      PS,
   output logic            IR_L,
   output logic [RA_W-1:0] AA,
   output logic [RA_W-1:0] BA,
   output logic [RA_W-1:0] DA,
   output logic            WR,
   output logic            Clr,
   output logic [4:0]      FS,
   output logic            Cin,
   output logic [4:0]      MuxD,
   output logic            MuxA,
   output logic [K_W-1:0]  K,
   output logic            MemWrite,
   output logic            mem_req,
   output logic [1:0]      SS,
   output logic            halted,
   output logic            fault
);

   state_t r_state;
   state_t w_next;
   logic   w_in_mem;
   logic   w_timeout;
   logic   w_unused_status;

   // V and C are not consulted by any branch.
   assign w_unused_status = ^status[3:2];

   assign w_in_mem = (r_state == ST_MEM);

   cpu_ctrl_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_inc     (w_in_mem && !mem_ready),
      .i_clr     (!w_in_mem || mem_ready || w_timeout),
      .o_timeout (w_timeout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= ST_RST;
      else
         r_state <= w_next;
   end

   // NOTE: every output and w_next gets a default before the case so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_next   = ST_RST;
      PS       = PS_HOLD;
      IR_L     = 1'b0;
      AA       = RA_W'(IR[5:3]);
      BA       = RA_W'(IR[2:0]);
      DA       = RA_W'(IR[8:6]);
      WR       = 1'b0;
      Clr      = 1'b0;
      FS       = '0;
      Cin      = 1'b0;
      MuxD     = MUXD_FU;
      MuxA     = 1'b0;
      K        = '0;
      MemWrite = 1'b0;
      mem_req  = 1'b0;
      SS       = SS_HOLD;
      halted   = 1'b0;
      fault    = 1'b0;

      case (r_state)
         ST_FETCH: begin
            IR_L   = 1'b1;
            w_next = ST_EXEC;
         end

         ST_EXEC: begin
            w_next = ST_FETCH;
            case (IR[15:14])
               CLS_ALU, CLS_IMM: begin
                  FS  = IR[13:9];
                  Cin = fs_uses_cin(IR[13:9]);
                  WR  = 1'b1;
                  SS  = SS_UPD;
                  PS  = PS_INC;
                  if (IR[15:14] == CLS_IMM) begin
                     MuxA = 1'b1;
                     K    = K_W'($signed(IR[2:0]));
                  end
               end
               CLS_MEM: w_next = ST_MEM;
               default: begin
                  case (IR[13:12])
                     CTL_BZ: begin
                        K  = K_W'($signed(IR[8:0]));
                        PS = status[0] ? PS_REL : PS_INC;
                     end
                     CTL_BN: begin
                        K  = K_W'($signed(IR[8:0]));
                        PS = status[1] ? PS_REL : PS_INC;
                     end
                     CTL_JMP: begin
                        PS = PS_REG;
                        if (IR[11]) begin
                           WR   = 1'b1;
                           MuxD = MUXD_PC1;
                        end
                     end
                     default: w_next = ST_HALT;
                  endcase
               end
            endcase
         end

         ST_MEM: begin
            mem_req = 1'b1;
            // A ready on the timeout cycle still completes the access.
            if (mem_ready) begin
               PS     = PS_INC;
               w_next = ST_FETCH;
               if (IR[9]) begin
                  MemWrite = 1'b1;
               end else begin
                  WR   = 1'b1;
                  MuxD = MUXD_MEM;
               end
            end else if (w_timeout) begin
               w_next = ST_FAULT;
            end else begin
               w_next = ST_MEM;
            end
         end

         ST_HALT: begin
            halted = 1'b1;
            w_next = run ? ST_FETCH : ST_HALT;
         end

         ST_FAULT: begin
            fault  = 1'b1;
            w_next = run ? ST_FETCH : ST_FAULT;
         end

         default: begin
            AA     = '0;
            BA     = '0;
            DA     = '0;
            Clr    = 1'b1;
            MuxD   = MUXD_ZERO;
            w_next = ST_FETCH;
         end
      endcase
   end

endmodule
